// File: rtl/binary_to_stochastic.sv
// Unipolar stochastic number generator: compares a saturated binary value against
// a full-period LFSR and emits the 2**LEN-bit stream serially and as a packed vector.
module binary_to_stochastic #(
  parameter int unsigned LEN  = 4,
  parameter int unsigned SEED = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LEN:0]           in_value,
  output logic                   sc_bit,
  output logic                   sc_bit_valid,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [(2**LEN)-1:0]    sc_num,
  output logic                   busy
);

  localparam int unsigned N = 2 ** LEN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [LEN-1:0] lfsr_q, lfsr_d;
  logic [LEN-1:0] cnt_q, cnt_d;
  logic [LEN:0]   val_q, val_d;
  logic [N-1:0]   sc_num_q, sc_num_d;

  logic           tap_fb;
  logic           fb;
  logic [LEN-1:0] lfsr_next;
  logic [LEN:0]   val_sat;

  // Maximal-length tap sets per stream length
  if (LEN == 5) begin : g_tap5
    assign tap_fb = lfsr_q[4] ^ lfsr_q[2];
  end else if (LEN == 8) begin : g_tap8
    assign tap_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  end else begin : g_tap_top2
    assign tap_fb = lfsr_q[LEN-1] ^ lfsr_q[LEN-2];
  end

  // de Bruijn extension splices the all-zero state into the sequence
  assign fb        = tap_fb ^ (lfsr_q[LEN-2:0] == '0);
  assign lfsr_next = {lfsr_q[LEN-2:0], fb};
  assign val_sat   = (in_value > (LEN+1)'(N)) ? (LEN+1)'(N) : in_value;

  assign in_ready     = (state_q == IDLE);
  assign sc_bit_valid = (state_q == RUN);
  assign out_valid    = (state_q == DONE);
  assign busy         = (state_q == RUN) || (state_q == DONE);
  assign sc_bit       = (state_q == RUN) && ({1'b0, lfsr_q} < val_q);
  assign sc_num       = sc_num_q;

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    val_d    = val_q;
    sc_num_d = sc_num_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          val_d    = val_sat;
          lfsr_d   = LEN'(SEED);
          cnt_d    = '0;
          sc_num_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        sc_num_d[cnt_q] = sc_bit;
        lfsr_d          = lfsr_next;
        cnt_d           = cnt_q + LEN'(1);
        if (cnt_q == LEN'(N - 1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lfsr_q   <= LEN'(SEED);
      cnt_q    <= '0;
      val_q    <= '0;
      sc_num_q <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      val_q    <= val_d;
      sc_num_q <= sc_num_d;
    end
  end

endmodule

// File: tb/tb_binary_to_stochastic.sv
// Directed bench for binary_to_stochastic (LEN=4); a second instance with SEED=0
// shares the stimulus so popcount is checked against two different seeds.
module tb_binary_to_stochastic;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [4:0]  in_value = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, sc_bit, sc_bit_valid, out_valid, busy;
  logic [15:0] sc_num;
  logic        in_ready_b, sc_bit_b, sc_bit_valid_b, out_valid_b, busy_b;
  logic [15:0] sc_num_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  binary_to_stochastic #(.LEN(4), .SEED(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .sc_bit(sc_bit), .sc_bit_valid(sc_bit_valid),
    .out_valid(out_valid), .out_ready(out_ready), .sc_num(sc_num), .busy(busy)
  );

  binary_to_stochastic #(.LEN(4), .SEED(0)) u_dut_s0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_value(in_value), .sc_bit(sc_bit_b), .sc_bit_valid(sc_bit_valid_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .sc_num(sc_num_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshake one value, walk the 16 RUN cycles, leave the DUT in DONE.
  task automatic run(input logic [4:0] v, output logic [15:0] bits);
    bits     = '0;
    in_value = v;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("run_sc_bit_valid", 32'(sc_bit_valid), 32'd1);
      check("run_out_valid_low", 32'(out_valid), 32'd0);
      bits[i] = sc_bit;
      step();
    end
    check("done_out_valid", 32'(out_valid), 32'd1);
    check("done_out_valid_s0", 32'(out_valid_b), 32'd1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("idle_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] bits;
    logic [15:0] exp5;
    exp5 = 16'h8017;

    step();
    step();
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sc_bit_valid", 32'(sc_bit_valid), 32'd0);
    check("rst_sc_bit", 32'(sc_bit), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sc_num", 32'(sc_num), 32'd0);

    // Value 5 with SEED=1: serial bits, latency and packed result
    in_value = 5'd5;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("v5_busy", 32'(busy), 32'd1);
    check("v5_in_ready_low", 32'(in_ready), 32'd0);
    for (int i = 0; i < 16; i++) begin
      check("v5_sc_bit", 32'(sc_bit), 32'(exp5[i]));
      check("v5_out_valid_low", 32'(out_valid), 32'd0);
      step();
    end
    check("v5_out_valid_17", 32'(out_valid), 32'd1);
    check("v5_sc_num", 32'(sc_num), 32'h8017);
    check("v5_popcount_s0", 32'($countones(sc_num_b)), 32'd5);

    // Backpressure: DONE holds, in_valid ignored
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_value = 5'd2;
      step();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_sc_num", 32'(sc_num), 32'h8017);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_sc_bit_valid", 32'(sc_bit_valid), 32'd0);
    end
    in_valid = 1'b0;
    release_out();
    check("rel_out_valid", 32'(out_valid), 32'd0);
    check("rel_busy", 32'(busy), 32'd0);
    run(5'd3, bits);
    check("after_bp_popcount", 32'($countones(sc_num)), 32'd3);
    check("after_bp_serial", 32'(bits), 32'(sc_num));
    release_out();

    // Boundaries and saturation
    run(5'd0, bits);
    check("v0_sc_num", 32'(sc_num), 32'h0000);
    check("v0_serial", 32'(bits), 32'h0000);
    release_out();
    run(5'd16, bits);
    check("v16_sc_num", 32'(sc_num), 32'hFFFF);
    release_out();
    run(5'd20, bits);
    check("v20_sc_num", 32'(sc_num), 32'hFFFF);
    check("v20_popcount", 32'($countones(sc_num)), 32'd16);
    check("v20_popcount_s0", 32'($countones(sc_num_b)), 32'd16);
    release_out();

    // Sweep: popcount equals the value for both seeds
    for (int v = 0; v <= 16; v++) begin
      run(5'(v), bits);
      check("sweep_popcount", 32'($countones(sc_num)), 32'(v));
      check("sweep_popcount_s0", 32'($countones(sc_num_b)), 32'(v));
      check("sweep_serial", 32'(bits), 32'(sc_num));
      release_out();
    end

    // Reset mid-RUN at cnt=7
    in_value = 5'd9;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    check("mrst_sc_num", 32'(sc_num), 32'd0);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_sc_bit_valid", 32'(sc_bit_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    run(5'd3, bits);
    check("mrst_popcount", 32'($countones(sc_num)), 32'd3);
    release_out();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
